// File: rtl/vga_timing_fetch.sv
// Raster timing generator and pixel fetch sequencer with PLL-lock qualification.
// Optional feature: define VGA_TEST_PATTERN_EN to add test_mode (8 vertical colour bars).
module vga_timing_fetch #(
    parameter int unsigned H_ACTIVE    = 1024,
    parameter int unsigned H_FP        = 24,
    parameter int unsigned H_SYNC      = 136,
    parameter int unsigned H_BP        = 144,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned V_FP        = 3,
    parameter int unsigned V_SYNC      = 6,
    parameter int unsigned V_BP        = 29,
    parameter int unsigned LOCK_SETTLE = 1024,
    parameter int unsigned FETCH_LEAD  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    output logic       req_valid,
    output logic [9:0] req_x,
    output logic [9:0] req_y,
    input  logic [7:0] pixel_data,
    output logic       frame_start,
    output logic       running,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned SW      = $clog2(LOCK_SETTLE);
    localparam int unsigned DEPTH   = FETCH_LEAD + 1;

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic [SW-1:0] SETTLE_LAST_C = SW'(LOCK_SETTLE - 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

`ifdef VGA_TEST_PATTERN_EN
    typedef struct packed {logic hs; logic vs; logic blank_n; logic [2:0] bar;} vid_t;
`else
    typedef struct packed {logic hs; logic vs; logic blank_n;} vid_t;
`endif

    localparam int unsigned VB = $bits(vid_t);
    localparam vid_t VID_IDLE = vid_t'({1'b1, 1'b1, {(VB-2){1'b0}}});

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [HW-1:0]        hcount_q, hcount_d;
    logic [VW-1:0]        vcount_q, vcount_d;
    logic                 req_valid_q, req_valid_d;
    logic [9:0]           req_x_q, req_x_d;
    logic [9:0]           req_y_q, req_y_d;
    logic                 frame_start_q, frame_start_d;
    logic                 running_q, running_d;
    logic [DEPTH*VB-1:0]  pipe_q, pipe_d;
    logic                 hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [7:0]           r_q, r_d, g_q, g_d, b_q, b_d;

    logic                 lock_s_c, flush_c, active_c;
    vid_t                 raw_c, last_c;
    logic [7:0]           pr_c, pg_c, pb_c;

    // Lock qualification FSM, raster counters and request generation
    always_comb begin
        sync_d        = {sync_q[0], pll_locked};
        lock_s_c      = sync_q[1];
        state_d       = state_q;
        settle_d      = settle_q;
        hcount_d      = '0;
        vcount_d      = '0;
        req_valid_d   = 1'b0;
        req_x_d       = req_x_q;
        req_y_d       = req_y_q;
        frame_start_d = 1'b0;
        flush_c       = 1'b0;
        active_c      = 1'b0;
        raw_c         = VID_IDLE;

        case (state_q)
            WAIT_LOCK: begin
                if (lock_s_c) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (!lock_s_c) begin
                    state_d = WAIT_LOCK;
                end else begin
                    settle_d = settle_q + 1'b1;
                    if (settle_d == SETTLE_LAST_C) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!lock_s_c) begin
                    state_d = WAIT_LOCK;
                    flush_c = 1'b1;
                end else begin
                    active_c      = (hcount_q < H_ACT_C) && (vcount_q < V_ACT_C);
                    req_valid_d   = active_c;
                    frame_start_d = active_c && (hcount_q == '0) && (vcount_q == '0);
                    if (active_c) begin
                        req_x_d = 10'(hcount_q);
                        req_y_d = 10'(vcount_q);
                    end
                    raw_c.hs      = ~((hcount_q >= HS_BEG_C) && (hcount_q < HS_END_C));
                    raw_c.vs      = ~((vcount_q >= VS_BEG_C) && (vcount_q < VS_END_C));
                    raw_c.blank_n = active_c;
`ifdef VGA_TEST_PATTERN_EN
                    raw_c.bar     = req_x_d[9:7];
`endif
                    if (hcount_q == H_LAST_C) begin
                        hcount_d = '0;
                        vcount_d = (vcount_q == V_LAST_C) ? '0 : vcount_q + 1'b1;
                    end else begin
                        hcount_d = hcount_q + 1'b1;
                        vcount_d = vcount_q;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        running_d = (state_d == RUN);
    end

    // Sync/blank delay line and colour expansion; pixel colour meets its delayed sync here
    always_comb begin
        pipe_d = flush_c ? {DEPTH{VID_IDLE}} : {pipe_q[(DEPTH-1)*VB-1:0], raw_c};
        last_c = vid_t'(pipe_q[DEPTH*VB-1 -: VB]);

        pr_c = {pixel_data[7:5], pixel_data[7:5], pixel_data[7:6]};
        pg_c = {pixel_data[4:2], pixel_data[4:2], pixel_data[4:3]};
        pb_c = {4{pixel_data[1:0]}};
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            pr_c = {8{last_c.bar[2]}};
            pg_c = {8{last_c.bar[1]}};
            pb_c = {8{last_c.bar[0]}};
        end
`endif

        hs_d      = last_c.hs;
        vs_d      = last_c.vs;
        blank_n_d = last_c.blank_n;
        r_d       = last_c.blank_n ? pr_c : 8'h00;
        g_d       = last_c.blank_n ? pg_c : 8'h00;
        b_d       = last_c.blank_n ? pb_c : 8'h00;
        if (flush_c) begin
            hs_d      = 1'b1;
            vs_d      = 1'b1;
            blank_n_d = 1'b0;
            r_d       = 8'h00;
            g_d       = 8'h00;
            b_d       = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= WAIT_LOCK;
            sync_q        <= '0;
            settle_q      <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            req_valid_q   <= 1'b0;
            req_x_q       <= '0;
            req_y_q       <= '0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
            pipe_q        <= {DEPTH{VID_IDLE}};
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            settle_q      <= settle_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            req_valid_q   <= req_valid_d;
            req_x_q       <= req_x_d;
            req_y_q       <= req_y_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
            pipe_q        <= pipe_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
        end
    end

    assign req_valid   = req_valid_q;
    assign req_x       = req_x_q;
    assign req_y       = req_y_q;
    assign frame_start = frame_start_q;
    assign running     = running_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule
